// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter that lends one shared external counter
// to NUM_REQ requesters. A winner gets its counter cleared, then counted up to
// its latched terminal value. Completion raises done; a counter overflow raises
// err. If the requester drops its request, or reset is asserted, the run is
// abandoned without a pulse.
module counter_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic                     busy,
  output logic                     cnt_reset,
  output logic                     cnt_enable,
  input  logic [CNT_W-1:0]         cnt_value,
  input  logic                     cnt_overflow
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [OW-1:0]    last_q, last_d;      // current owner while busy, last owner when idle
  logic [CNT_W-1:0] target_q, target_d;
  logic             abort_q, abort_d;

  logic             pick_found;
  logic [OW-1:0]    pick_idx;
  int               k;
  logic             owner_req;
  logic [NUM_REQ-1:0] owner_oh;

  assign owner_req = req[last_q];
  assign owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << last_q;

  // Round-robin search starting one past the previous owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    k          = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last_q) + i) % NUM_REQ;
      if (!pick_found && req[OW'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = OW'(k);
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    target_d   = target_q;
    abort_d    = abort_q;
    gnt        = '0;
    done       = '0;
    err        = 1'b0;
    busy       = 1'b1;
    cnt_reset  = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (pick_found) begin
          last_d   = pick_idx;
          target_d = len[pick_idx*CNT_W +: CNT_W];
          abort_d  = 1'b0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        gnt       = owner_oh;
        cnt_reset = 1'b1;
        state_d   = owner_req ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        gnt        = owner_oh;
        cnt_enable = (cnt_value != target_q);
        // Withdrawal beats overflow, which beats normal completion.
        if (!owner_req) begin
          state_d = S_IDLE;
        end else if (cnt_overflow) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else if (cnt_value == target_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt     = owner_oh;
        done    = abort_q ? '0 : owner_oh;
        err     = abort_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset leaves the last owner at the top index, so the
  // first search after reset begins at requester 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= OW'(NUM_REQ - 1);
      target_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      target_q <= target_d;
      abort_q  <= abort_d;
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Testbench for counter_arbiter. The bench models the shared counter and uses a
// run-level reference: round-robin owner choice and cycle timing that follow
// from the latched length.
module tb_counter_arbiter;
  localparam int N = 3;
  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   gnt, done;
  logic           err, busy, cnt_reset, cnt_enable;
  logic [W-1:0]   cnt_value;
  logic           cnt_overflow;
  logic           force_ovf;

  int tests = 0;
  int fails = 0;
  int m_last;

  counter_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len),
    .gnt(gnt), .done(done), .err(err), .busy(busy),
    .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
    .cnt_value(cnt_value), .cnt_overflow(cnt_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter: synchronous clear, count enable, sticky overflow.
  logic [W-1:0] cnt_q = '0;
  logic         ovf_q = 1'b0;
  always_ff @(posedge clk) begin
    if (cnt_reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (cnt_enable) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '1) ovf_q <= 1'b1;
    end
  end
  assign cnt_value    = cnt_q;
  assign cnt_overflow = ovf_q | force_ovf;

  wire [3*N+4-1:0] obs = {gnt, done, err, busy, cnt_reset, cnt_enable};

  function automatic int pick(input logic [N-1:0] m, input int last);
    for (int i = 1; i <= N; i++)
      if (m[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // Called at the negedge of the IDLE cycle with req already set.
  task automatic start_run(output int own, output int L);
    own = pick(req, m_last);
    if (own < 0) own = 0;
    m_last = own;
    L = int'(len[own*W +: W]);
  endtask

  // Walks cycles 1 .. 3+L of a normal run and checks every output each cycle.
  task automatic check_run(input int own, input int L, input bit scramble);
    logic [N-1:0] oh;
    logic [3*N+4-1:0] exp_v;
    oh = N'(1) << own;
    for (int c = 1; c <= 3 + L; c++) begin
      @(negedge clk);
      exp_v = {oh, (c == 3 + L) ? oh : {N{1'b0}}, 1'b0, 1'b1,
               1'(c == 1), 1'(c >= 2 && c < 2 + L)};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL run own=%0d len=%0d cyc=%0d got %b exp %b", own, L, c, obs, exp_v);
      end
      if (c == 3 + L) begin
        tests++;
        if (cnt_value !== W'(L)) begin
          fails++;
          $display("FAIL cnt_value own=%0d got %0d exp %0d", own, cnt_value, L);
        end
      end
      if (scramble && c == 1) begin
        len = N*W'($urandom);
        req = N'($urandom) | oh;
      end
    end
  endtask

  task automatic check_idle(input string nm);
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL %s got %b exp %b", nm, obs, {(3*N+4){1'b0}});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #3;
    check_idle("reset_outputs");
    @(negedge clk);
    reset = 1'b0;
    m_last = N - 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; len = '0; force_ovf = 1'b0;
    #3;
    check_idle("reset_async");
    @(negedge clk);
    reset = 1'b0;
    m_last = N - 1;
    @(negedge clk);
    check_idle("idle_no_req_a");
    @(negedge clk);
    check_idle("idle_no_req_b");
  endtask

  task automatic test_single();
    int own, L;
    req = 3'b001;
    len = {4'd9, 4'd7, 4'd5};
    start_run(own, L);
    check_run(own, L, 1'b0);
    req = '0;
    @(negedge clk);
    check_idle("single_after");
  endtask

  task automatic test_boundaries();
    int own, L;
    req = 3'b001; len = {4'd3, 4'd3, 4'd0};
    start_run(own, L);
    check_run(own, L, 1'b0);
    req = '0;
    @(negedge clk);
    check_idle("len0_after");
    req = 3'b001; len = {4'd1, 4'd1, 4'd15};
    start_run(own, L);
    check_run(own, L, 1'b0);
    req = '0;
    @(negedge clk);
    check_idle("len15_after");
  endtask

  task automatic test_round_robin();
    int own, L;
    do_reset();
    req = 3'b111; len = {4'd2, 4'd2, 4'd2};
    for (int r = 0; r < 4; r++) begin
      start_run(own, L);
      check_run(own, L, 1'b0);
      @(negedge clk);
      check_idle("rr_gap");
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int own, L;
    logic [N-1:0] oh;
    req = 3'b010; len = {4'd10, 4'd10, 4'd10};
    start_run(own, L);
    oh = N'(1) << own;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== {oh, {N{1'b0}}, 1'b0, 1'b1, 1'(c == 1), 1'(c >= 2)}) begin
        fails++;
        $display("FAIL ovf_pre cyc=%0d got %b", c, obs);
      end
    end
    force_ovf = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== {oh, {N{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL ovf_done got %b exp %b", obs, {oh, {N{1'b0}}, 1'b1, 1'b1, 2'b00});
    end
    force_ovf = 1'b0;
    req = '0;
    @(negedge clk);
    check_idle("ovf_after");
  endtask

  task automatic test_withdraw();
    int own, L;
    req = 3'b100; len = {4'd10, 4'd10, 4'd10};
    start_run(own, L);
    for (int c = 1; c <= 3; c++) @(negedge clk);
    tests++;
    if (gnt !== (N'(1) << own) || cnt_enable !== 1'b1) begin
      fails++;
      $display("FAIL wd_run got gnt=%b en=%b exp gnt=%b en=1", gnt, cnt_enable, N'(1) << own);
    end
    req = '0;
    @(negedge clk);
    check_idle("wd_next");
    @(negedge clk);
    check_idle("wd_next2");
  endtask

  task automatic test_reset_midrun();
    int own, L;
    req = 3'b010; len = {4'd10, 4'd10, 4'd10};
    start_run(own, L);
    for (int c = 1; c <= 3; c++) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle("reset_midrun_async");
    @(negedge clk);
    check_idle("reset_midrun_held");
    reset = 1'b0;
    m_last = N - 1;
    req = 3'b011; len = {4'd4, 4'd4, 4'd1};
    start_run(own, L);
    check_run(own, L, 1'b0);
    req = '0;
    @(negedge clk);
    check_idle("reset_midrun_after");
  endtask

  task automatic test_random();
    int own, L;
    for (int r = 0; r < 40; r++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      len = N*W'($urandom);
      start_run(own, L);
      check_run(own, L, 1'b1);
      @(negedge clk);
      check_idle("rand_gap");
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_round_robin();
    test_overflow();
    test_withdraw();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, SHALL set the number of requesters sharing one external counter (range 2..4).
REQ-002 Parameter CNT_W, default 4, SHALL set the width of the shared counter value and of each requested length.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port req  input  NUM_REQ  SHALL carry one request bit per requester; a requester holds its bit high until it sees its done pulse.
REQ-006 Port len  input  NUM_REQ*CNT_W  SHALL carry the packed terminal counts; requester i occupies bits [i*CNT_W +: CNT_W].
REQ-007 Port gnt  output  NUM_REQ  SHALL be one-hot on the current owner while a run is active, else all zero.
REQ-008 Port done  output  NUM_REQ  SHALL pulse one cycle on the owner's bit at normal run completion.
REQ-009 Port err  output  1  SHALL pulse one cycle when a run aborts on counter overflow.
REQ-010 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-011 Port cnt_reset  output  1  SHALL drive the shared counter's synchronous clear.
REQ-012 Port cnt_enable  output  1  SHALL drive the shared counter's count enable.
REQ-013 Port cnt_value  input  CNT_W  SHALL be the shared counter's current registered value.
REQ-014 Port cnt_overflow  input  1  SHALL be the shared counter's sticky overflow flag (cleared by cnt_reset).

Function
REQ-015 The block SHALL implement FSM states IDLE, CLEAR, RUN, DONE; only one run is active at a time.
REQ-016 IDLE: when any req bit is high, the block SHALL select the owner round-robin, searching from (last_owner+1) mod NUM_REQ upward, latch len[owner] into target, record last_owner=owner, and go to CLEAR.
REQ-017 IDLE with req all zero SHALL remain in IDLE; gnt, done, err, cnt_reset, cnt_enable all 0.
REQ-018 CLEAR SHALL last exactly one cycle with cnt_reset=1, cnt_enable=0, then go to RUN.
REQ-019 RUN: cnt_enable SHALL equal (cnt_value != target), decoded combinationally in the same cycle; cnt_reset=0.
REQ-020 RUN with cnt_value == target SHALL go to DONE; target 0 therefore yields zero increments.
REQ-021 RUN with cnt_overflow=1 SHALL take priority over REQ-020 and go to DONE with abort flag set.
REQ-022 RUN or CLEAR with req[owner]=0 (requester withdrawal) SHALL go directly to IDLE; no done, no err pulse.
REQ-023 DONE SHALL last one cycle: done[owner]=1 if not aborted, else err=1 and done all zero; gnt still asserted; then IDLE.
REQ-024 gnt SHALL be one-hot(owner) in CLEAR, RUN and DONE.
REQ-025 Latency: req sampled in IDLE at cycle 0 -> CLEAR at cycle 1 -> RUN from cycle 2 -> done at cycle 3+target -> IDLE at cycle 4+target.
REQ-026 Exactly target counter increments SHALL occur per completed run; no wrap-around is permitted within a run.
REQ-027 A new arbitration SHALL occur only in IDLE; req changes by non-owners during a run SHALL have no effect until IDLE.
REQ-028 len changes after the owner is latched SHALL not affect the active run.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, last_owner=NUM_REQ-1, target=0, abort flag 0, independent of clk.
REQ-030 During and after reset all outputs SHALL be 0 (gnt, done, err, busy, cnt_reset, cnt_enable).
REQ-031 Reset asserted mid-run SHALL abandon the run with no done or err pulse; first grant after reset goes to the lowest-index active requester.

Verification
REQ-032 Single request: req=3'b001, len[0]=5 -> gnt=001 cycle 1, cnt_reset cycle 1, cnt_enable high cycles 2..6, done=001 at cycle 8, cnt_value ends at 5.
REQ-033 Round-robin: req=3'b111 held, all len=2 -> grants in order 0,1,2,0, each done before next gnt, one IDLE cycle between runs.
REQ-034 Boundaries: len=0 -> done at cycle 3 with no cnt_enable; len=15 -> 15 increments, done at cycle 18, err=0.
REQ-035 Overflow abort: force cnt_overflow=1 during RUN -> DONE next cycle with err=1, done=000, then IDLE.
REQ-036 Withdrawal and reset: drop req[owner] mid-RUN -> IDLE next cycle, no pulses; assert reset mid-RUN -> all outputs 0 without waiting for clk, next grant to requester 0.
